// File: rtl/ecc_op_sequencer.sv
// Operation controller for the ECC datapath: snapshots mode/width on start, walks the
// encoder and/or decoder through their pipeline latencies and registers the final result.
module ecc_op_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ENC_LATENCY = 1,
  parameter int DEC_LATENCY = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            ctrl,
  input  logic [1:0]            codeword_width,
  input  logic [DATA_WIDTH-1:0] data_out_enc,
  input  logic [DATA_WIDTH-1:0] data_out_dec,
  input  logic [1:0]            dec_num_errors,
  output logic                  cfg_load,
  output logic [1:0]            mode_q,
  output logic [1:0]            width_q,
  output logic                  enc_en,
  output logic                  dec_en,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            num_of_errors,
  output logic                  operation_done,
  output logic                  start_dropped,
  output logic [CNT_WIDTH-1:0]  op_count
);

  localparam int MAX_LAT = (ENC_LATENCY > DEC_LATENCY) ? ENC_LATENCY : DEC_LATENCY;
  localparam int WCW     = $clog2(MAX_LAT + 1);

  localparam logic [WCW-1:0] ENC_LOAD = WCW'(ENC_LATENCY);
  localparam logic [WCW-1:0] DEC_LOAD = WCW'(DEC_LATENCY);
  localparam logic [WCW-1:0] LAST     = WCW'(1);

  localparam logic [1:0] MODE_DEC  = 2'b01;
  localparam logic [1:0] MODE_FULL = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ENC_WAIT,
    DEC_WAIT,
    DONE
  } state_t;

  state_t         state;
  logic [WCW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the result registers are reset too, so data_out is never X between operations.
      state          <= IDLE;
      wait_cnt       <= '0;
      cfg_load       <= 1'b0;
      mode_q         <= 2'b00;
      width_q        <= 2'b00;
      enc_en         <= 1'b0;
      dec_en         <= 1'b0;
      busy           <= 1'b0;
      data_out       <= '0;
      num_of_errors  <= 2'b00;
      operation_done <= 1'b0;
      start_dropped  <= 1'b0;
      op_count       <= '0;
    end else begin
      // NOTE: strobes default low each cycle and are raised only on the edge entering their state.
      cfg_load       <= 1'b0;
      enc_en         <= 1'b0;
      dec_en         <= 1'b0;
      operation_done <= 1'b0;

      if (start && (state != IDLE)) begin
        start_dropped <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            mode_q   <= ctrl;
            width_q  <= codeword_width;
            cfg_load <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end

        LOAD: begin
          if (mode_q == MODE_DEC) begin
            wait_cnt <= DEC_LOAD;
            dec_en   <= 1'b1;
            state    <= DEC_WAIT;
          end else begin
            wait_cnt <= ENC_LOAD;
            enc_en   <= 1'b1;
            state    <= ENC_WAIT;
          end
        end

        ENC_WAIT: begin
          if (wait_cnt == LAST) begin
            if (mode_q == MODE_FULL) begin
              wait_cnt <= DEC_LOAD;
              dec_en   <= 1'b1;
              state    <= DEC_WAIT;
            end else begin
              data_out       <= data_out_enc;
              num_of_errors  <= 2'b00;
              operation_done <= 1'b1;
              op_count       <= op_count + CNT_WIDTH'(1);
              state          <= DONE;
            end
          end else begin
            wait_cnt <= wait_cnt - LAST;
            enc_en   <= 1'b1;
          end
        end

        DEC_WAIT: begin
          if (wait_cnt == LAST) begin
            data_out       <= data_out_dec;
            num_of_errors  <= dec_num_errors;
            operation_done <= 1'b1;
            op_count       <= op_count + CNT_WIDTH'(1);
            state          <= DONE;
          end else begin
            wait_cnt <= wait_cnt - LAST;
            dec_en   <= 1'b1;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ecc_op_sequencer.md
Name: ecc_op_sequencer

Overview:
Operation controller for the ECC encoder/decoder datapath. It accepts the start pulse and CTRL/CODEWORD_WIDTH values from the APB register bank, and snapshots the configuration. It then sequences the encoder and/or decoder through their pipeline latencies, and registers the final data_out/num_of_errors with a one-cycle operation_done. It sits between the register bank and the ENC/DEC instances in the top level.

Parameters:
DATA_WIDTH, 32, codeword/data width of datapath results
ENC_LATENCY, 1, encoder cycles from enc_en to valid data_out_enc (>=1)
DEC_LATENCY, 2, decoder cycles from dec_en to valid data_out_dec/num_of_errors (>=1)
CNT_WIDTH, 16, width of completed-operation counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle request from register bank
ctrl  in  2  mode: 00 encode-only, 01 decode-only, 10 full channel, 11 treated as encode-only
codeword_width  in  2  width code, passed through snapshot
data_out_enc  in  DATA_WIDTH  encoder result
data_out_dec  in  DATA_WIDTH  decoder result
dec_num_errors  in  2  decoder error count
cfg_load  out  1  one-cycle strobe: datapath latches mode/width
mode_q  out  2  snapshotted ctrl, stable for whole operation
width_q  out  2  snapshotted codeword_width
enc_en  out  1  high during encoder wait
dec_en  out  1  high during decoder wait
busy  out  1  high in any state except IDLE
data_out  out  DATA_WIDTH  registered result
num_of_errors  out  2  registered error count
operation_done  out  1  one-cycle completion pulse
start_dropped  out  1  sticky: start seen while busy
op_count  out  CNT_WIDTH  completed operations, wraps

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE. All outputs 0, including op_count and start_dropped. Reset mid-operation aborts immediately with no operation_done. Reset dominates start.
- States: IDLE, LOAD, ENC_WAIT, DEC_WAIT, DONE.
- IDLE: start=1 -> LOAD. On the same edge, mode_q<=ctrl and width_q<=codeword_width.
- LOAD (1 cycle): cfg_load=1. Next state is DEC_WAIT if mode_q=01, else ENC_WAIT.
- ENC_WAIT: enc_en=1 for exactly ENC_LATENCY cycles, using down-counter wait_cnt loaded on entry.
  - When the count expires: mode_q=10 -> DEC_WAIT; otherwise capture data_out<=data_out_enc and num_of_errors<=0, then DONE.
- DEC_WAIT: dec_en=1 for exactly DEC_LATENCY cycles.
  - When the count expires: capture data_out<=data_out_dec and num_of_errors<=dec_num_errors, then DONE.
- wait_cnt width is $clog2(max(ENC_LATENCY,DEC_LATENCY)+1).
- DONE (1 cycle): operation_done=1 and op_count<=op_count+1 (mod 2^CNT_WIDTH). Next state is IDLE.
- Latency, with start sampled at edge N:
  - operation_done is high in cycle N+2+ENC_LATENCY for encode-only/11.
  - It is high in cycle N+2+DEC_LATENCY for decode-only.
  - It is high in cycle N+2+ENC_LATENCY+DEC_LATENCY for full channel.
  - Defaults give N+3 / N+4 / N+5.
- Back-to-back: start is accepted only in IDLE, so the minimum spacing is one IDLE cycle after DONE.
- start while busy (LOAD..DONE): ignored and start_dropped<=1 (sticky until rst). It does not affect mode_q/width_q or the operation in flight.
- ctrl/codeword_width changes during an operation have no effect; only the snapshot is used.
- data_out/num_of_errors hold their last captured value between operations and are never X after reset.
- enc_en and dec_en are never high together. cfg_load, enc_en and dec_en are all 0 in IDLE and DONE.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, operation_done=0, data_out=0, num_of_errors=0, op_count=0.
- Encode-only: ctrl=00, start at N, data_out_enc=32'hA5A5_0F0F -> cfg_load at N+1, enc_en at N+2, operation_done at N+3 only, data_out=32'hA5A5_0F0F, num_of_errors=0, op_count=1.
- Full channel: ctrl=10, dec_num_errors=2'b01, data_out_dec=32'h0000_1234 -> enc_en at N+2, dec_en at N+3..N+4, done at N+5, data_out=32'h0000_1234, num_of_errors=01.
- Decode-only, with ctrl changed to 00 and start pulsed at N+2 -> still decode path, done at N+4, start_dropped=1, only one operation_done.
- rst asserted in DEC_WAIT of a full-channel op -> next cycle IDLE, no operation_done, all outputs 0; a new start then completes normally.
- 2^CNT_WIDTH+1 back-to-back encode ops (CNT_WIDTH=4 override) -> op_count wraps 15->0->1; ctrl=11 behaves identically to 00.
